// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the MIPS multiply/divide unit.
// Op codes, FSM states and the iteration count.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for magnitudes
// and for sign correction of results.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU with architectural HI/LO.
// One bit per cycle; product and remainder:quotient share one register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic             i_abort,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] pfix;
  logic [WIDTH-1:0]   qfix, rfix;

  assign sgn = i_op[0];

  muldiv_signfix #(.W(WIDTH)) u_mag_a (
    .val_i(i_opa), .neg_i(sgn & i_opa[WIDTH-1]), .res_o(mag_a)
  );
  muldiv_signfix #(.W(WIDTH)) u_mag_b (
    .val_i(i_opb), .neg_i(sgn & i_opb[WIDTH-1]), .res_o(mag_b)
  );
  muldiv_signfix #(.W(2*WIDTH)) u_fix_p (
    .val_i(prod_q), .neg_i(sa_q ^ sb_q), .res_o(pfix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_q (
    .val_i(prod_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .res_o(qfix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_r (
    .val_i(prod_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .res_o(rfix)
  );

  logic [WIDTH:0]     madd, dsh, dsub;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx;

  // Shift-add multiply: accumulate in the upper half, shift right.
  assign madd   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (prod_q[0] ? b_q : '0)};
  assign mul_nx = {madd, prod_q[WIDTH-1:1]};

  // Restoring divide: remainder on top, quotient bits shift in below.
  assign dsh    = prod_q[2*WIDTH-1:WIDTH-1];
  assign ge     = dsh >= {1'b0, b_q};
  assign dsub   = dsh - {1'b0, b_q};
  assign div_nx = {(ge ? dsub[WIDTH-1:0] : dsh[WIDTH-1:0]),
                   prod_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          div_d   = i_op[1];
          sa_d    = sgn & i_opa[WIDTH-1];
          sb_d    = sgn & i_opb[WIDTH-1];
          dz_d    = i_op[1] & (i_opb == '0);
          b_d     = mag_b;
          prod_d  = {{WIDTH{1'b0}}, mag_a};
        end else begin
          if (i_mthi) hi_d = i_wdata;
          if (i_mtlo) lo_d = i_wdata;
        end
      end
      S_CALC: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          prod_d = div_q ? div_nx : mul_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!i_abort) begin
          done_d = 1'b1;
          // With a zero divisor the remainder already equals the dividend.
          if (div_q) begin
            hi_d = rfix;
            lo_d = dz_q ? '1 : qfix;
          end else begin
            {hi_d, lo_d} = pfix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_opa = '0;
  logic [31:0] i_opb = '0;
  logic        i_abort = 1'b0;
  logic        i_mthi = 1'b0;
  logic        i_mtlo = 1'b0;
  logic [31:0] i_wdata = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int total = 0;
  int passes = 0;

  muldiv_unit dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_op   (i_op),
    .i_opa  (i_opa),
    .i_opb  (i_opb),
    .i_abort(i_abort),
    .i_mthi (i_mthi),
    .i_mtlo (i_mtlo),
    .i_wdata(i_wdata),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_hi   (o_hi),
    .o_lo   (o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    i_op    = op;
    i_opa   = a;
    i_opb   = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // 'already' = cycles elapsed since the start edge, all busy.
  task automatic wait_done(input string tag, input int already);
    int n;
    int bc;
    n  = already;
    bc = already;
    while (!o_done && n < 40) begin
      if (o_busy) bc++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busycyc"}, 64'(bc), 64'd33);
    chk({tag, "_busy_lo"}, 64'(o_busy), 64'd0);
    tick();
    chk({tag, "_done1cy"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int dseen;
    #2;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);
    #10 i_rst_n = 1'b1;
    tick();

    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy", 64'(o_busy), 64'd1);
    chk("multu_hold", {32'h0, o_lo}, 64'd0);
    wait_done("multu", 0);
    chk("multu_res", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);

    launch(2'b01, 32'hFFFF_FFFD, 32'd7);
    repeat (4) tick();
    i_op    = 2'b00;
    i_opa   = 32'd100;
    i_opb   = 32'd100;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("mult", 5);
    chk("mult_res", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 0);
    chk("div_res", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf", 0);
    chk("divovf_res", {o_hi, o_lo}, 64'h0000_0000_8000_0000);

    launch(2'b10, 32'h64, 32'h0);
    wait_done("divz", 0);
    chk("divz_res", {o_hi, o_lo}, 64'h0000_0064_FFFF_FFFF);

    i_mthi  = 1'b1;
    i_wdata = 32'h1234;
    tick();
    i_mthi  = 1'b0;
    chk("mthi_res", {o_hi, o_lo}, 64'h0000_1234_FFFF_FFFF);

    launch(2'b10, 32'd10, 32'd3);
    repeat (9) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd0);
    dseen = 0;
    repeat (3) begin
      if (o_done) dseen++;
      tick();
    end
    chk("abort_nodone", 64'(dseen), 64'd0);
    chk("abort_hilo", {o_hi, o_lo}, 64'h0000_1234_FFFF_FFFF);

    i_mtlo  = 1'b1;
    i_wdata = 32'hDEAD;
    launch(2'b00, 32'd2, 32'd3);
    i_mtlo  = 1'b0;
    chk("startwin_busy", 64'(o_busy), 64'd1);
    chk("startwin_lo", {32'h0, o_lo}, 64'h0000_0000_FFFF_FFFF);
    wait_done("post_abort", 0);
    chk("post_abort_res", {o_hi, o_lo}, 64'h0000_0000_0000_0006);

    launch(2'b01, 32'd5, 32'hFFFF_FFFE);
    repeat (14) tick();
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_hilo", {o_hi, o_lo}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    launch(2'b00, 32'd6, 32'd7);
    wait_done("after_rst", 0);
    chk("after_rst_res", {o_hi, o_lo}, 64'h0000_0000_0000_002A);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
